uart_psram_bridge: RTL
======================

// Module: uart_psram_bridge
// PURPOSE
//  Host command front end for the PSRAM controller: parses framed UART RX bytes into single 16-bit
//  PSRAM read/write transactions, drives address/read_write/data_in with a req/done handshake, and
//  returns status or read data as UART TX bytes. Sits between uart_rx/uart_tx and psram, all on mem_clk.
// PARAMETERS
//  FRAME_TIMEOUT  24'd8_400_000  idle cycles between RX bytes before a partial frame is discarded (~100 ms @84 MHz)
//  MEM_TIMEOUT    16'd256        cycles to wait for mem_done before aborting with error reply
// PORTS
//  mem_clk     in   1   system clock, all logic on posedge
//  rst_n       in   1   asynchronous active-low reset
//  rx_data     in   8   received UART byte
//  rx_valid    in   1   1-cycle strobe, rx_data valid
//  tx_data     out  8   byte to transmit
//  tx_valid    out  1   tx_data valid; held until tx_ready
//  tx_ready    in   1   transmitter accepts byte when tx_valid&&tx_ready
//  mem_ready   in   1   PSRAM initialised (psram qpi_on)
//  mem_req     out  1   transaction request; held until mem_done
//  mem_rw      out  1   1=read, 0=write (to psram read_write)
//  mem_addr    out  24  byte address, MSB first on wire
//  mem_wdata   out  16  write data (to psram data_in)
//  mem_rdata   in   16  read data (psram data_out), valid with mem_done on read
//  mem_done    in   1   1-cycle completion strobe (endcommand for write, read_psram for read)
//  rx_drop     out  1   1-cycle pulse: RX byte arrived while not accepting
// BEHAVIOUR
//  Reset: state=IDLE; tx_data=0, tx_valid=0, mem_req=0, mem_rw=0, mem_addr=0, mem_wdata=0, rx_drop=0, counters=0.
//  Frames: 'W'(0x57) A2 A1 A0 D1 D0 -> write; 'R'(0x52) A2 A1 A0 -> read. A2/D1 first (MSB).
//  Replies: write ok 0x4B 'K'; read ok D1 then D0; unknown cmd 0x3F '?'; mem_ready low 0x42 'B';
//   mem timeout 0x45 'E'. Frame timeout sends nothing.
//  States: IDLE -> ADDR (3 bytes) -> [WDATA (2 bytes, write only)] -> MEM_REQ -> MEM_WAIT -> RESP -> IDLE.
//   IDLE on rx_valid: 'W'/'R' latch mem_rw -> ADDR; other byte -> RESP with '?'.
//   ADDR/WDATA shift bytes into mem_addr/mem_wdata; byte counter 2 bits.
//   After last frame byte: if mem_ready=0 -> RESP 'B', no mem_req; else MEM_REQ.
//   MEM_REQ: mem_req=1 registered, i.e. asserts the cycle after the last byte is accepted; -> MEM_WAIT.
//   MEM_WAIT: mem_req held; mem_addr/mem_rw/mem_wdata stable. On mem_done: mem_req=0 next cycle, read
//    latches mem_rdata same edge; -> RESP. Watchdog counts from mem_req rise; at MEM_TIMEOUT w/o done:
//    mem_req=0, RESP 'E'. mem_done outside MEM_WAIT ignored.
//  RESP: tx_valid=1 with byte; advance on tx_valid&&tx_ready; read sends 2 bytes back-to-back
//   (tx_valid stays 1 between them); after final handshake tx_valid=0 next cycle -> IDLE.
//  Frame timeout: counter clears on every accepted rx_valid in ADDR/WDATA; reaching FRAME_TIMEOUT
//   -> IDLE, partial frame discarded, no mem_req, no reply. Counter idle outside ADDR/WDATA.
//  rx_valid in MEM_REQ/MEM_WAIT/RESP: byte discarded, rx_drop=1 for one cycle; no state change.
//  Simultaneous rx_valid and frame-timeout terminal count: byte accepted, timeout ignored.
//  mem_ready falling during MEM_WAIT: transaction continues; watchdog governs.
//  rst_n low mid-operation: immediately all outputs to reset values, including mem_req=0 and
//   tx_valid=0; in-flight transaction abandoned, nothing replayed after release.
//  One transaction outstanding at a time; no pipelining of frames.
// TESTING
//  1 W 00 01 02 AB CD, mem_ready=1, done 10 cyc later -> mem_req 1 cyc after last byte, addr=0x000102,
//    rw=0, wdata=0xABCD held to done; TX 0x4B.
//  2 R 00 01 02, mem_rdata=0x1234 with done -> rw=1; TX 0x12 then 0x34; tx_ready stalled 5 cyc holds 0x12.
//  3 Byte 0x41 in IDLE -> TX 0x3F, no mem_req; W frame with mem_ready=0 -> TX 0x42, no mem_req.
//  4 R 00 then silence FRAME_TIMEOUT cyc -> IDLE, no TX; next R 00 00 10 completes normally.
//  5 Write with no mem_done -> mem_req drops after 256 cyc, TX 0x45; extra rx bytes during wait -> rx_drop pulses.
//  6 rst_n low during MEM_WAIT -> mem_req=0, tx_valid=0 asynchronously; after release a new frame works.

Source files
------------

// File: rtl/uart_psram_bridge.sv
// Purpose: turns framed host bytes from the UART into single 16-bit PSRAM reads/writes and returns replies.
// Latency: mem_req rises 1 cycle after the last frame byte; the first reply byte 1 cycle after mem_done.
// Backpressure: tx_valid is held until tx_ready; RX bytes arriving while busy are dropped and flagged on rx_drop.
module uart_psram_bridge #(
  parameter logic [23:0] FRAME_TIMEOUT = 24'd8_400_000,
  parameter logic [15:0] MEM_TIMEOUT   = 16'd256
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        rx_drop
);

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_UNK   = 8'h3F;  // '?'
  localparam logic [7:0] RSP_BUSY  = 8'h42;  // 'B'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  tx_data_d;
  logic        tx_valid_d;
  logic        mem_req_d;
  logic        mem_rw_d;
  logic [23:0] mem_addr_d;
  logic [15:0] mem_wdata_d;
  logic        rx_drop_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] ft_cnt_q, ft_cnt_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic [7:0]  rdata_lo_q, rdata_lo_d;
  logic        two_byte_q, two_byte_d;
  logic        frame_end;

  // State and datapath registers; async reset forces every output idle at once.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      mem_req    <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rx_drop    <= 1'b0;
      byte_cnt_q <= '0;
      ft_cnt_q   <= '0;
      wd_cnt_q   <= '0;
      rdata_lo_q <= '0;
      two_byte_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      mem_req    <= mem_req_d;
      mem_rw     <= mem_rw_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      rx_drop    <= rx_drop_d;
      byte_cnt_q <= byte_cnt_d;
      ft_cnt_q   <= ft_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      rdata_lo_q <= rdata_lo_d;
      two_byte_q <= two_byte_d;
    end
  end

  // Next-state and next-output logic: frame parsing, memory handshake, watchdogs and reply sequencing.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    mem_req_d   = mem_req;
    mem_rw_d    = mem_rw;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rx_drop_d   = 1'b0;
    byte_cnt_d  = byte_cnt_q;
    ft_cnt_d    = ft_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    rdata_lo_d  = rdata_lo_q;
    two_byte_d  = two_byte_q;
    frame_end   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ft_cnt_d = '0;
        if (rx_valid) begin
          byte_cnt_d = '0;
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            mem_rw_d = (rx_data == CMD_READ);
            state_d  = S_ADDR;
          end else begin
            tx_data_d  = RSP_UNK;
            tx_valid_d = 1'b1;
            two_byte_d = 1'b0;
            state_d    = S_RESP;
          end
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          // A byte on the terminal-count cycle still counts; the frame lives on.
          ft_cnt_d   = '0;
          mem_addr_d = {mem_addr[15:0], rx_data};
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = '0;
            if (mem_rw) frame_end = 1'b1;
            else        state_d   = S_WDATA;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (ft_cnt_q == FRAME_TIMEOUT) begin
          ft_cnt_d = '0;
          state_d  = S_IDLE;
        end else begin
          ft_cnt_d = ft_cnt_q + 24'd1;
        end
      end

      S_WDATA: begin
        if (rx_valid) begin
          ft_cnt_d    = '0;
          mem_wdata_d = {mem_wdata[7:0], rx_data};
          if (byte_cnt_q == 2'd1) begin
            byte_cnt_d = '0;
            frame_end  = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (ft_cnt_q == FRAME_TIMEOUT) begin
          ft_cnt_d = '0;
          state_d  = S_IDLE;
        end else begin
          ft_cnt_d = ft_cnt_q + 24'd1;
        end
      end

      S_MEM_REQ: begin
        rx_drop_d = rx_valid;
        wd_cnt_d  = wd_cnt_q + 16'd1;
        state_d   = S_MEM_WAIT;
      end

      S_MEM_WAIT: begin
        rx_drop_d = rx_valid;
        if (mem_done) begin
          mem_req_d  = 1'b0;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
          if (mem_rw) begin
            tx_data_d  = mem_rdata[15:8];
            rdata_lo_d = mem_rdata[7:0];
            two_byte_d = 1'b1;
          end else begin
            tx_data_d  = RSP_OK;
            two_byte_d = 1'b0;
          end
        end else if (wd_cnt_q == MEM_TIMEOUT - 16'd1) begin
          // mem_req has now been high for MEM_TIMEOUT cycles without completion.
          mem_req_d  = 1'b0;
          tx_data_d  = RSP_ERR;
          tx_valid_d = 1'b1;
          two_byte_d = 1'b0;
          state_d    = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end

      S_RESP: begin
        rx_drop_d = rx_valid;
        if (tx_valid && tx_ready) begin
          if (two_byte_q) begin
            // Low data byte follows immediately, tx_valid never drops between them.
            tx_data_d  = rdata_lo_q;
            two_byte_d = 1'b0;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Completed frame: refuse immediately if the PSRAM is not up, otherwise launch the request.
    if (frame_end) begin
      if (!mem_ready) begin
        tx_data_d  = RSP_BUSY;
        tx_valid_d = 1'b1;
        two_byte_d = 1'b0;
        state_d    = S_RESP;
      end else begin
        mem_req_d = 1'b1;
        wd_cnt_d  = '0;
        state_d   = S_MEM_REQ;
      end
    end
  end

endmodule
